// File: rtl/fp_alu_host_driver.sv
// fp_alu_host_driver
// Host-side master for the byte-serial FP ALU pin protocol. Takes one operation
// (A, B, opcode) on a valid/ready request port, pulses alu_start, streams the
// eight operand bytes LSB-first (A then B), waits for alu_done (bounded by
// TIMEOUT_CYCLES), collects four result bytes LSB-first and presents the
// 32-bit result on a valid/ready response port.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   req_valid/ready/a/b/op   request port (ready only in IDLE)
//   rsp_valid/ready/data     response port, data held while valid
//   rsp_timeout              response is a timeout abort (data = 0)
//   alu_in/opcode/start      ALU pin outputs
//   alu_done/out             ALU pin inputs
//   busy                     high in every state except IDLE
module fp_alu_host_driver #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [1:0]  req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        rsp_timeout,
  output logic [7:0]  alu_in,
  output logic [1:0]  alu_opcode,
  output logic        alu_start,
  input  logic        alu_done,
  input  logic [7:0]  alu_out,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE,
    START,
    SEND,
    WAIT_DONE,
    RECV,
    RESP
  } state_t;

  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;
  logic [2:0]  r_beat;
  logic [15:0] r_tmo;
  logic [31:0] r_rsp_data;
  logic        r_timeout;
  logic        r_alu_start;
  logic        w_req_fire;
  logic [63:0] w_send_word;

  assign w_req_fire  = req_valid && req_ready;
  assign w_send_word = {r_b, r_a};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:      if (w_req_fire) w_next = START;
      START:     w_next = SEND;
      SEND:      if (r_beat == 3'd7) w_next = WAIT_DONE;
      // done wins over a same-cycle timeout
      WAIT_DONE: if (alu_done) w_next = RECV;
                 else if (r_tmo == TMO_LAST) w_next = RESP;
      RECV:      if (r_beat == 3'd3) w_next = RESP;
      RESP:      if (rsp_ready) w_next = IDLE;
      default:   w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a         <= '0;
      r_b         <= '0;
      r_op        <= '0;
      r_beat      <= '0;
      r_tmo       <= '0;
      r_rsp_data  <= '0;
      r_timeout   <= 1'b0;
      r_alu_start <= 1'b0;
    end else begin
      // start pulse comes from a flop so it cannot glitch on state decode
      r_alu_start <= (w_next == START);
      case (r_state)
        IDLE: begin
          if (w_req_fire) begin
            r_a  <= req_a;
            r_b  <= req_b;
            r_op <= req_op;
          end
        end
        START: begin
          r_beat <= '0;
          r_tmo  <= '0;
        end
        SEND: r_beat <= r_beat + 3'd1;
        WAIT_DONE: begin
          if (alu_done) begin
            r_rsp_data <= {24'd0, alu_out};
            r_timeout  <= 1'b0;
            r_beat     <= 3'd1;
          end else if (r_tmo == TMO_LAST) begin
            r_rsp_data <= '0;
            r_timeout  <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        RECV: begin
          r_rsp_data[{r_beat[1:0], 3'b000} +: 8] <= alu_out;
          r_beat <= r_beat + 3'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    alu_in     = '0;
    alu_opcode = '0;
    if (r_state == SEND) alu_in = w_send_word[{r_beat, 3'b000} +: 8];
    if (r_state == START || r_state == SEND || r_state == WAIT_DONE || r_state == RECV)
      alu_opcode = r_op;
  end

  assign alu_start   = r_alu_start;
  assign rsp_valid   = (r_state == RESP);
  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_timeout;
  assign busy        = (r_state != IDLE);
  assign req_ready   = (r_state == IDLE) && !rst;

endmodule

// File: tb/tb_fp_alu_host_driver.sv
// Testbench for fp_alu_host_driver: acts as the ALU on the pin side and as
// requester/consumer on the host side, checking every cycle of each operation.
module tb_fp_alu_host_driver;

  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic [1:0]  req_op;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_timeout;
  logic [7:0]  alu_in;
  logic [1:0]  alu_opcode;
  logic        alu_start;
  logic        alu_done;
  logic [7:0]  alu_out;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  fp_alu_host_driver #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_op     (req_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_timeout(rsp_timeout),
    .alu_in     (alu_in),
    .alu_opcode (alu_opcode),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_out    (alu_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return 8'((w >> (8 * i)) & 32'hFF);
  endfunction

  // delay < 0: ALU never answers. rst_beat >= 0: reset during that SEND beat.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                        input logic [31:0] res, input int delay, input int rst_beat,
                        input bit spurious, input int hold);
    int n;
    int nw;
    int guard;
    logic [7:0] eb;
    n = 0;
    rsp_ready = 1'b0;
    @(negedge clk);
    req_a = a; req_b = b; req_op = op; req_valid = 1'b1;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    n = 1;
    req_valid = 1'b0;
    req_a = $urandom; req_b = $urandom; req_op = 2'($urandom);
    check("start_pulse", 32'(alu_start), 32'd1);
    check("start_opcode", 32'(alu_opcode), 32'(op));
    check("start_in", 32'(alu_in), 32'd0);
    check("start_busy", 32'(busy), 32'd1);
    check("start_req_ready", 32'(req_ready), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n++;
      alu_done = 1'b0;
      if (spurious && k == 3) begin
        alu_done = 1'b1;
        alu_out = 8'($urandom);
      end
      eb = (k < 4) ? byte_of(a, k) : byte_of(b, k - 4);
      check("send_byte", 32'(alu_in), 32'(eb));
      check("send_start_low", 32'(alu_start), 32'd0);
      check("send_opcode", 32'(alu_opcode), 32'(op));
      if (k == rst_beat) begin
        #2 rst = 1'b1;
        #1;
        check("rst_alu_in", 32'(alu_in), 32'd0);
        check("rst_alu_start", 32'(alu_start), 32'd0);
        check("rst_alu_opcode", 32'(alu_opcode), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_timeout", 32'(rsp_timeout), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        alu_done = 1'b0;
        return;
      end
    end
    nw = (delay < 0) ? TMO : delay + 1;
    for (int w = 0; w < nw; w++) begin
      @(negedge clk);
      n++;
      alu_done = 1'b0;
      check("wait_in", 32'(alu_in), 32'd0);
      check("wait_opcode", 32'(alu_opcode), 32'(op));
      check("wait_no_rsp", 32'(rsp_valid), 32'd0);
      if (w == delay) begin
        alu_done = 1'b1;
        alu_out = byte_of(res, 0);
      end
    end
    if (delay >= 0) begin
      for (int j = 1; j < 4; j++) begin
        @(negedge clk);
        n++;
        alu_done = 1'($urandom_range(0, 1));
        alu_out = byte_of(res, j);
        check("recv_opcode", 32'(alu_opcode), 32'(op));
        check("recv_no_rsp", 32'(rsp_valid), 32'd0);
      end
    end
    @(negedge clk);
    n++;
    alu_done = 1'b0;
    alu_out = 8'($urandom);
    guard = 0;
    while (!rsp_valid && guard < 40) begin
      @(negedge clk);
      n++;
      guard++;
    end
    check("rsp_latency", 32'(n), (delay < 0) ? 32'(10 + TMO) : 32'(14 + delay));
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("rsp_data", rsp_data, (delay < 0) ? 32'd0 : res);
    check("rsp_timeout", 32'(rsp_timeout), (delay < 0) ? 32'd1 : 32'd0);
    check("rsp_opcode_clear", 32'(alu_opcode), 32'd0);
    req_valid = 1'b1;
    req_a = $urandom; req_b = $urandom;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("hold_valid", 32'(rsp_valid), 32'd1);
      check("hold_data", rsp_data, (delay < 0) ? 32'd0 : res);
      check("hold_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rsp_busy", 32'(busy), 32'd0);
    check("post_rsp_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    check("idle_rsp_valid", 32'(rsp_valid), 32'd0);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0;
    rsp_ready = 1'b0; alu_done = 1'b0; alu_out = '0;
    #12;
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_req_ready", 32'(req_ready), 32'd0);
    check("reset_alu_start", 32'(alu_start), 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check("reset_release_ready", 32'(req_ready), 32'd1);

    run_op(32'h3F800000, 32'h40000000, 2'd0, 32'h40400000, 2, -1, 1'b0, 5);
    run_op($urandom, $urandom, 2'd1, $urandom, -1, -1, 1'b0, 1);
    run_op($urandom, $urandom, 2'd2, 32'h12345678, TMO - 1, -1, 1'b0, 0);
    run_op($urandom, $urandom, 2'd3, 32'hDDCCBBAA, 4, -1, 1'b1, 2);
    run_op($urandom, $urandom, 2'd1, $urandom, 3, 4, 1'b0, 0);
    run_op(32'hC0000000, 32'h3F800000, 2'd2, 32'hBF800000, 1, -1, 1'b0, 0);
    for (int i = 0; i < 20; i++) begin
      run_op($urandom, $urandom, 2'($urandom), $urandom,
             ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, TMO - 1)),
             -1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
